// File: rtl/window_gen_3x3.sv
// window_gen_3x3: turns a raster pixel stream into 3x3 windows for a downstream FIFO.
// Two line buffers hold rows r-1 and r-2. Two column registers hold the previous two
// window columns. No padding is applied, so only windows fully inside the frame are emitted.
// A finished window waits in data_out with pend set until the FIFO takes it.
module window_gen_3x3 #(
  parameter int DATA_WIDTH = 16,
  parameter int D          = 3,
  parameter int F          = 3,   // window edge; the datapath is built for 3 only
  parameter int IMG_W      = 256,
  parameter int IMG_H      = 256
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         pix_valid,
  input  logic [D*DATA_WIDTH-1:0]      pix_in,
  output logic                         pix_ready,
  input  logic                         fifo_full,
  output logic                         write,
  output logic [D*F*F*DATA_WIDTH-1:0]  data_out,
  output logic                         frame_done
);
  localparam int PW = D*DATA_WIDTH;
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  state_t              r_state;
  logic [CW-1:0]       r_col;
  logic [RW-1:0]       r_row;
  logic                r_pend;
  logic [8:0][PW-1:0]  r_win;
  logic [PW-1:0]       r_lb1 [IMG_W];   // row r-1
  logic [PW-1:0]       r_lb2 [IMG_W];   // row r-2
  logic [2:0][PW-1:0]  r_c0, r_c1;      // window columns c-2 and c-1, index = window row

  logic                w_accept, w_last_col, w_last_row, w_win_ok;
  logic [2:0][PW-1:0]  w_cn;            // incoming column: oldest row first
  logic [8:0][PW-1:0]  w_win;

  assign pix_ready  = (r_state == STREAM) && !(r_pend && fifo_full);
  assign write      = r_pend && !fifo_full;
  assign frame_done = (r_state == DONE);
  assign data_out   = r_win;

  assign w_accept   = pix_valid && pix_ready;
  assign w_last_col = (r_col == CW'(IMG_W-1));
  assign w_last_row = (r_row == RW'(IMG_H-1));
  assign w_win_ok   = (r_row >= RW'(2)) && (r_col >= CW'(2));

  assign w_cn[0] = r_lb2[r_col];
  assign w_cn[1] = r_lb1[r_col];
  assign w_cn[2] = pix_in;

  // Element (r,c) sits at slot r*3+c. The newest pixel lands at slot 8.
  for (genvar r = 0; r < 3; r++) begin : g_pack
    assign w_win[r*3+0] = r_c0[r];
    assign w_win[r*3+1] = r_c1[r];
    assign w_win[r*3+2] = w_cn[r];
  end

  // Pixel storage advances only on accept. It needs no reset because stale data never reaches a window.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lb2[r_col] <= r_lb1[r_col];
      r_lb1[r_col] <= pix_in;
      r_c0         <= r_c1;
      r_c1         <= w_cn;
    end
  end

  // Control: frame FSM, raster counters, and the pending-window handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_row   <= '0;
      r_col   <= '0;
      r_pend  <= 1'b0;
      r_win   <= '0;
    end else begin
      // A fresh window may replace one being written in the same cycle.
      if (w_accept && w_win_ok) begin
        r_win  <= w_win;
        r_pend <= 1'b1;
      end else if (write) begin
        r_pend <= 1'b0;
      end
      case (r_state)
        IDLE: if (start) begin
          r_state <= STREAM;
          r_row   <= '0;
          r_col   <= '0;
        end
        STREAM: if (w_accept) begin
          if (w_last_col) begin
            r_col <= '0;
            if (w_last_row) begin
              r_row   <= '0;
              r_state <= DRAIN;
            end else begin
              r_row <= r_row + RW'(1);
            end
          end else begin
            r_col <= r_col + CW'(1);
          end
        end
        DRAIN: if (!r_pend || write) r_state <= DONE;
        DONE:  r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_window_gen_3x3.sv
// Directed bench: a 4x4 single-channel instance and a 5x3 three-channel instance.
module tb_window_gen_3x3;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         reset = 1'b1;
  logic         start1 = 0, pv1 = 0, full1 = 0, rdy1, wr1, fd1;
  logic [7:0]   pin1 = '0;
  logic [71:0]  dout1;
  logic         start2 = 0, pv2 = 0, full2 = 0, rdy2, wr2, fd2;
  logic [47:0]  pin2 = '0;
  logic [431:0] dout2;

  window_gen_3x3 #(.DATA_WIDTH(8), .D(1), .F(3), .IMG_W(4), .IMG_H(4)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .pix_valid(pv1), .pix_in(pin1),
    .pix_ready(rdy1), .fifo_full(full1), .write(wr1), .data_out(dout1), .frame_done(fd1));

  window_gen_3x3 #(.DATA_WIDTH(16), .D(3), .F(3), .IMG_W(5), .IMG_H(3)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .pix_valid(pv2), .pix_in(pin2),
    .pix_ready(rdy2), .fifo_full(full2), .write(wr2), .data_out(dout2), .frame_done(fd2));

  int checks = 0, errors = 0;
  logic [71:0]  wq1[$];
  int           wc1[$];
  int           acc1[16];
  int           fd1_cnt = 0, fd1_cyc = -1;
  logic [431:0] wq2[$];
  int           fd2_cnt = 0;

  // Recorder: writes, accept cycles, and done pulses, all sampled mid-cycle.
  always @(negedge clk) begin
    if (wr1) begin wq1.push_back(dout1); wc1.push_back(cyc); end
    if (rdy1 && pv1) acc1[pin1[3:0]] = cyc;
    if (fd1) begin fd1_cnt++; fd1_cyc = cyc; end
    if (wr2) wq2.push_back(dout2);
    if (fd2) fd2_cnt++;
  end

  // Reference window n of the 4x4 frame, where pixel = row*4+col and windows are in raster order.
  function automatic logic [71:0] exp1(input int n);
    logic [71:0] w;
    int rr, cc;
    rr = n / 2;
    cc = n % 2;
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w[(r*3+c)*8 +: 8] = 8'((rr+r)*4 + cc + c);
    return w;
  endfunction

  task automatic clr1();
    wq1.delete(); wc1.delete(); fd1_cnt = 0; fd1_cyc = -1;
    for (int i = 0; i < 16; i++) acc1[i] = -1;
  endtask

  task automatic pulse_start1();
    start1 = 1; @(posedge clk); #1; start1 = 0;
  endtask

  // Drive pixels 0..stop-1 of the 4x4 frame.
  // Options: random valid gaps; stall the FIFO after a given pixel; pulse start around a given pixel.
  task automatic run1(input bit rnd, input int full_px, input int start_px, input int stop);
    bit acc;
    int t;
    for (int p = 0; p < stop; p++) begin
      if (rnd && $urandom_range(0, 1) == 1) begin pv1 = 0; @(posedge clk); #1; end
      pv1 = 1; pin1 = 8'(p);
      if (p == start_px) start1 = 1;
      acc = 0; t = 0;
      while (!acc && t < 100) begin
        @(negedge clk); acc = rdy1 && pv1; @(posedge clk); #1; t++;
      end
      start1 = 0;
      if (!acc) begin
        checks++; errors++;
        $display("FAIL accept_timeout px %0d: got no accept, want accept", p);
      end
      if (p == full_px) begin
        full1 = 1;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          checks += 3;
          if (wr1 !== 1'b0) begin errors++; $display("FAIL full_write: got %b want 0", wr1); end
          if (rdy1 !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", rdy1); end
          if (dout1 !== exp1(0)) begin errors++; $display("FAIL full_hold: got %h want %h", dout1, exp1(0)); end
          @(posedge clk); #1;
        end
        full1 = 0;
      end
    end
    pv1 = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks += 8;
    if (wr1 !== 1'b0)   begin errors++; $display("FAIL rst_write1: got %b want 0", wr1); end
    if (rdy1 !== 1'b0)  begin errors++; $display("FAIL rst_ready1: got %b want 0", rdy1); end
    if (fd1 !== 1'b0)   begin errors++; $display("FAIL rst_done1: got %b want 0", fd1); end
    if (dout1 !== '0)   begin errors++; $display("FAIL rst_data1: got %h want 0", dout1); end
    if (wr2 !== 1'b0)   begin errors++; $display("FAIL rst_write2: got %b want 0", wr2); end
    if (rdy2 !== 1'b0)  begin errors++; $display("FAIL rst_ready2: got %b want 0", rdy2); end
    if (fd2 !== 1'b0)   begin errors++; $display("FAIL rst_done2: got %b want 0", fd2); end
    if (dout2 !== '0)   begin errors++; $display("FAIL rst_data2: got %h want 0", dout2); end
    @(posedge clk); #1; reset = 0;
  endtask

  task automatic test_basic();
    int lf[9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    int ll[9] = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
    logic [71:0] ef, el;
    for (int k = 0; k < 9; k++) begin ef[k*8 +: 8] = 8'(lf[k]); el[k*8 +: 8] = 8'(ll[k]); end
    clr1();
    pulse_start1();
    run1(0, -1, -1, 16);
    repeat (20) @(posedge clk); #1;
    checks++;
    if (wq1.size() != 4) begin errors++; $display("FAIL basic_count: got %0d want 4", wq1.size()); end
    for (int i = 0; i < wq1.size() && i < 4; i++) begin
      checks++;
      if (wq1[i] !== exp1(i)) begin errors++; $display("FAIL basic_win%0d: got %h want %h", i, wq1[i], exp1(i)); end
    end
    if (wq1.size() == 4) begin
      checks += 3;
      if (wq1[0] !== ef) begin errors++; $display("FAIL basic_first: got %h want %h", wq1[0], ef); end
      if (wq1[3] !== el) begin errors++; $display("FAIL basic_last: got %h want %h", wq1[3], el); end
      if (wc1[0] != acc1[10] + 1) begin
        errors++; $display("FAIL basic_latency: got cycle %0d want %0d", wc1[0], acc1[10] + 1);
      end
    end
    checks += 2;
    if (fd1_cnt != 1) begin errors++; $display("FAIL basic_done: got %0d pulses want 1", fd1_cnt); end
    if (rdy1 !== 1'b0) begin errors++; $display("FAIL basic_idle_ready: got %b want 0", rdy1); end
  endtask

  task automatic test_fifo_full();
    clr1();
    pulse_start1();
    run1(0, 10, -1, 16);
    repeat (20) @(posedge clk); #1;
    checks++;
    if (wq1.size() != 4) begin errors++; $display("FAIL full_count: got %0d want 4", wq1.size()); end
    for (int i = 0; i < wq1.size() && i < 4; i++) begin
      checks++;
      if (wq1[i] !== exp1(i)) begin errors++; $display("FAIL full_win%0d: got %h want %h", i, wq1[i], exp1(i)); end
    end
  endtask

  task automatic test_gaps();
    clr1();
    pulse_start1();
    run1(1, -1, -1, 16);
    repeat (20) @(posedge clk); #1;
    checks++;
    if (wq1.size() != 4) begin errors++; $display("FAIL gaps_count: got %0d want 4", wq1.size()); end
    for (int i = 0; i < wq1.size() && i < 4; i++) begin
      checks++;
      if (wq1[i] !== exp1(i)) begin errors++; $display("FAIL gaps_win%0d: got %h want %h", i, wq1[i], exp1(i)); end
    end
  endtask

  task automatic test_start_ignored();
    clr1();
    pulse_start1();
    run1(0, -1, 5, 16);
    repeat (20) @(posedge clk); #1;
    checks += 3;
    if (wq1.size() != 4) begin errors++; $display("FAIL sti_count: got %0d want 4", wq1.size()); end
    if (fd1_cnt != 1) begin errors++; $display("FAIL sti_done: got %0d pulses want 1", fd1_cnt); end
    if (rdy1 !== 1'b0) begin errors++; $display("FAIL sti_idle_ready: got %b want 0", rdy1); end
    if (wq1.size() == 4) begin
      checks += 2;
      if (fd1_cyc != wc1[3] + 1) begin
        errors++; $display("FAIL sti_done_cycle: got %0d want %0d", fd1_cyc, wc1[3] + 1);
      end
      if (wq1[3] !== exp1(3)) begin errors++; $display("FAIL sti_last: got %h want %h", wq1[3], exp1(3)); end
    end
  endtask

  task automatic test_reset_midframe();
    clr1();
    pulse_start1();
    run1(0, -1, -1, 9);
    pv1 = 1; pin1 = 8'd9;
    reset = 1;
    @(posedge clk);
    @(negedge clk);
    checks += 4;
    if (wr1 !== 1'b0)  begin errors++; $display("FAIL mid_rst_write: got %b want 0", wr1); end
    if (rdy1 !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: got %b want 0", rdy1); end
    if (fd1 !== 1'b0)  begin errors++; $display("FAIL mid_rst_done: got %b want 0", fd1); end
    if (dout1 !== '0)  begin errors++; $display("FAIL mid_rst_data: got %h want 0", dout1); end
    @(posedge clk); #1;
    reset = 0; pv1 = 0;
    clr1();
    repeat (5) @(posedge clk); #1;
    checks++;
    if (wq1.size() != 0) begin errors++; $display("FAIL mid_no_write: got %0d writes want 0", wq1.size()); end
    pulse_start1();
    run1(0, -1, -1, 16);
    repeat (20) @(posedge clk); #1;
    checks++;
    if (wq1.size() != 4) begin errors++; $display("FAIL mid_count: got %0d want 4", wq1.size()); end
    for (int i = 0; i < wq1.size() && i < 4; i++) begin
      checks++;
      if (wq1[i] !== exp1(i)) begin errors++; $display("FAIL mid_win%0d: got %h want %h", i, wq1[i], exp1(i)); end
    end
  endtask

  task automatic test_multi_ch();
    logic [431:0] e;
    bit acc;
    int t;
    wq2.delete(); fd2_cnt = 0;
    start2 = 1; @(posedge clk); #1; start2 = 0;
    for (int p = 0; p < 15; p++) begin
      pv2 = 1;
      for (int ch = 0; ch < 3; ch++) pin2[ch*16 +: 16] = 16'(p*16 + ch);
      acc = 0; t = 0;
      while (!acc && t < 100) begin
        @(negedge clk); acc = rdy2 && pv2; @(posedge clk); #1; t++;
      end
      if (!acc) begin
        checks++; errors++;
        $display("FAIL mc_accept_timeout px %0d: got no accept, want accept", p);
      end
    end
    pv2 = 0;
    repeat (20) @(posedge clk); #1;
    checks += 2;
    if (wq2.size() != 3) begin errors++; $display("FAIL mc_count: got %0d want 3", wq2.size()); end
    if (fd2_cnt != 1) begin errors++; $display("FAIL mc_done: got %0d pulses want 1", fd2_cnt); end
    for (int n = 0; n < wq2.size() && n < 3; n++) begin
      e = '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          for (int ch = 0; ch < 3; ch++)
            e[((r*3+c)*3+ch)*16 +: 16] = 16'((r*5 + n + c)*16 + ch);
      checks++;
      if (wq2[n] !== e) begin errors++; $display("FAIL mc_win%0d: got %h want %h", n, wq2[n], e); end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) acc1[i] = -1;
    #1;
    test_reset();
    test_basic();
    test_fifo_full();
    test_gaps();
    test_start_ignored();
    test_reset_midframe();
    test_multi_ch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
